// File: rtl/sub8_serial.sv
// Nibble-serial saturating subtractor: {src1,src0} - src2 over LO/HI steps,
// with signed/unsigned clipping and a sticky count of clipped results.
module sub8_serial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] src0,
  input  logic [3:0] src1,
  input  logic [3:0] src2,
  input  logic       sign_s1,
  input  logic       sign_s2,
  input  logic       i_sign_d,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] dst0,
  output logic [3:0] dst1,
  output logic       out_sat,
  input  logic       sat_clr,
  output logic [7:0] sat_cnt
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] m_q, m_d;
  logic [3:0] s_q, s_d;
  logic       signed_q, signed_d;
  logic [3:0] dlo_q, dlo_d;
  logic       b0_q, b0_d;
  logic [3:0] dst0_q, dst0_d;
  logic [3:0] dst1_q, dst1_d;
  logic       out_sat_q, out_sat_d;
  logic [7:0] sat_cnt_q, sat_cnt_d;

  logic [4:0] lo_diff;
  logic [4:0] m_hi, s_hi, d_hi;
  logic [8:0] d_full;
  logic [7:0] result;
  logic       clip;

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    s_d       = s_q;
    signed_d  = signed_q;
    dlo_d     = dlo_q;
    b0_d      = b0_q;
    dst0_d    = dst0_q;
    dst1_d    = dst1_q;
    out_sat_d = out_sat_q;
    sat_cnt_d = sat_cnt_q;

    // Low nibble of the subtrahend is src2 itself in both modes.
    lo_diff = {1'b0, m_q[3:0]} - {1'b0, s_q};
    m_hi    = signed_q ? {m_q[7], m_q[7:4]} : {1'b0, m_q[7:4]};
    s_hi    = signed_q ? {5{s_q[3]}} : 5'b0;
    d_hi    = m_hi - s_hi - {4'b0, b0_q};
    d_full  = {d_hi, dlo_q};

    result = d_full[7:0];
    clip   = 1'b0;
    if (signed_q && d_full[8:7] == 2'b10) begin
      result = 8'h80;
      clip   = 1'b1;
    end else if (signed_q && d_full[8:7] == 2'b01) begin
      result = 8'h7F;
      clip   = 1'b1;
    end else if (!signed_q && d_full[8]) begin
      result = 8'h00;
      clip   = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d      = {src1, src0};
          s_d      = src2;
          signed_d = sign_s1 | sign_s2 | i_sign_d;
          state_d  = LO;
        end
      end
      LO: begin
        dlo_d   = lo_diff[3:0];
        b0_d    = lo_diff[4];
        state_d = HI;
      end
      HI: begin
        dst0_d    = result[3:0];
        dst1_d    = result[7:4];
        out_sat_d = clip;
        if (clip && sat_cnt_q != 8'hFF) sat_cnt_d = sat_cnt_q + 8'd1;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (sat_clr) sat_cnt_d = 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= 8'h00;
      s_q       <= 4'h0;
      signed_q  <= 1'b0;
      dlo_q     <= 4'h0;
      b0_q      <= 1'b0;
      dst0_q    <= 4'h0;
      dst1_q    <= 4'h0;
      out_sat_q <= 1'b0;
      sat_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      s_q       <= s_d;
      signed_q  <= signed_d;
      dlo_q     <= dlo_d;
      b0_q      <= b0_d;
      dst0_q    <= dst0_d;
      dst1_q    <= dst1_d;
      out_sat_q <= out_sat_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dst0      = dst0_q;
  assign dst1      = dst1_q;
  assign out_sat   = out_sat_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_sub8_serial.sv
// Directed bench for sub8_serial: hand-computed vectors, backpressure,
// reset abort and sat_cnt edge cases.
module tb_sub8_serial;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] src0, src1, src2;
  logic       sign_s1, sign_s2, i_sign_d;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] dst0, dst1;
  logic       out_sat;
  logic       sat_clr;
  logic [7:0] sat_cnt;

  int checks = 0;
  int errors = 0;

  sub8_serial dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .src0(src0), .src1(src1), .src2(src2),
    .sign_s1(sign_s1), .sign_s2(sign_s2), .i_sign_d(i_sign_d),
    .out_valid(out_valid), .out_ready(out_ready),
    .dst0(dst0), .dst1(dst1), .out_sat(out_sat),
    .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, LO, HI, DONE, then take the result.
  // sgn = {sign_s1, sign_s2, i_sign_d}; clr_hi pulses sat_clr in the HI cycle.
  task automatic do_op(input string tag, input logic [7:0] m, input logic [3:0] s,
                       input logic [2:0] sgn, input logic [7:0] exp_res,
                       input logic exp_sat, input logic [7:0] exp_cnt,
                       input logic clr_hi, input logic full_chk);
    if (full_chk) check({tag, "_in_ready_idle"}, in_ready, 1'b1);
    {src1, src0} = m;
    src2 = s;
    {sign_s1, sign_s2, i_sign_d} = sgn;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    {src1, src0} = ~m;
    src2 = ~s;
    {sign_s1, sign_s2, i_sign_d} = ~sgn;
    if (full_chk) begin
      check({tag, "_ov_lo"}, out_valid, 1'b0);
      check({tag, "_ir_lo"}, in_ready, 1'b0);
    end
    step();
    if (full_chk) check({tag, "_ov_hi"}, out_valid, 1'b0);
    sat_clr = clr_hi;
    step();
    sat_clr = 1'b0;
    check({tag, "_ov_done"}, out_valid, 1'b1);
    check({tag, "_res"}, {dst1, dst0}, exp_res);
    check({tag, "_sat"}, out_sat, exp_sat);
    check({tag, "_cnt"}, sat_cnt, exp_cnt);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    if (full_chk) begin
      check({tag, "_ir_after"}, in_ready, 1'b1);
      check({tag, "_ov_after"}, out_valid, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
    src0 = 4'h0; src1 = 4'h0; src2 = 4'h0;
    sign_s1 = 1'b0; sign_s2 = 1'b0; i_sign_d = 1'b0;
    #23;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_dst", {dst1, dst0}, 8'h00);
    check("rst_sat", out_sat, 1'b0);
    check("rst_cnt", sat_cnt, 8'h00);
    rst_n = 1'b1;
    step();

    do_op("u_noclip",  8'h34, 4'h5, 3'b000, 8'h2F, 1'b0, 8'h00, 1'b0, 1'b1);
    do_op("u_under",   8'h03, 4'h9, 3'b000, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1);

    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("clr_idle", sat_cnt, 8'h00);

    do_op("s_neg_clip", 8'h80, 4'h1, 3'b010, 8'h80, 1'b1, 8'h01, 1'b0, 1'b1);
    do_op("s_pos_clip", 8'h7E, 4'hE, 3'b100, 8'h7F, 1'b1, 8'h02, 1'b0, 1'b1);
    do_op("s_borrow",   8'hF0, 4'h8, 3'b001, 8'hF8, 1'b0, 8'h02, 1'b0, 1'b1);
    do_op("s_minus_neg",8'h05, 4'hF, 3'b100, 8'h06, 1'b0, 8'h02, 1'b0, 1'b1);
    do_op("u_borrow",   8'h10, 4'h1, 3'b000, 8'h0F, 1'b0, 8'h02, 1'b0, 1'b1);
    do_op("u_ff",       8'hFF, 4'hF, 3'b000, 8'hF0, 1'b0, 8'h02, 1'b0, 1'b1);

    // Backpressure: hold out_ready low in DONE with in_valid pushing.
    src1 = 4'h0; src0 = 4'h0; src2 = 4'h1;
    {sign_s1, sign_s2, i_sign_d} = 3'b000;
    in_valid = 1'b1;
    step();
    src2 = 4'h2;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_ov", out_valid, 1'b1);
      check("bp_ir", in_ready, 1'b0);
      check("bp_res", {dst1, dst0, out_sat}, {8'h00, 1'b1});
      check("bp_cnt", sat_cnt, 8'h03);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_ir_after", in_ready, 1'b1);
    check("bp_ov_after", out_valid, 1'b0);
    do_op("bp_next", 8'h34, 4'h5, 3'b000, 8'h2F, 1'b0, 8'h03, 1'b0, 1'b1);

    // Reset asserted in HI aborts the clipping operation.
    src1 = 4'h8; src0 = 4'h0; src2 = 4'h1;
    {sign_s1, sign_s2, i_sign_d} = 3'b010;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_hi_ov", out_valid, 1'b0);
    check("rst_hi_ir", in_ready, 1'b1);
    check("rst_hi_cnt", sat_cnt, 8'h00);
    #3 rst_n = 1'b1;
    step();
    step();
    check("rst_rel_ov", out_valid, 1'b0);
    check("rst_rel_ir", in_ready, 1'b1);
    check("rst_rel_cnt", sat_cnt, 8'h00);
    do_op("rst_fresh", 8'h34, 4'h5, 3'b000, 8'h2F, 1'b0, 8'h00, 1'b0, 1'b1);

    // sat_clr in the same cycle as a clipping HI step wins.
    do_op("pre_clr", 8'h03, 4'h9, 3'b000, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1);
    do_op("clr_hi",  8'h03, 4'h9, 3'b000, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1);

    // Saturation of sat_cnt at 0xFF.
    for (int i = 1; i <= 256; i++) begin
      logic [7:0] exp_c;
      exp_c = (i >= 255) ? 8'hFF : 8'(i);
      do_op("sat_run", 8'h00, 4'h1, 3'b000, 8'h00, 1'b1, exp_c, 1'b0, 1'b0);
    end
    check("sat_sticky", sat_cnt, 8'hFF);
    do_op("sat_noclip", 8'h34, 4'h5, 3'b000, 8'h2F, 1'b0, 8'hFF, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
